// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of hazard inputs and pipeline-register controls that
// connects the 5-stage core datapath to the hazard/sequencing controller.
//
// Signals (direction as seen by the controller, modport slave):
//   id_r1Num, id_r2Num       in   decode-stage source register numbers
//   id_r1Used, id_r2Used     in   decode instruction actually reads that source
//   ex_memReadEnable         in   instruction in EX is a load
//   ex_regWriteEnable        in   instruction in EX writes a register
//   ex_regWriteNum           in   destination of the EX instruction
//   ex_halt                  in   halt instruction is in EX
//   ex_branchTaken           in   EX resolved a redirect (branch/jump/siic)
//   imem_stall, dmem_stall   in   instruction / data memory busy
//   pc_en .. memwb_en        out  pipeline register enables
//   ifid_flush, idex_flush   out  load a NOP into IF/ID, ID/EX on this edge
//   halted                   out  core stopped
//   stall_cnt, flush_cnt     out  performance counters
//
// Modports: master = datapath side, slave = controller side.
interface pipe_ctrl_if;
  logic [2:0]  id_r1Num;
  logic [2:0]  id_r2Num;
  logic        id_r1Used;
  logic        id_r2Used;
  logic        ex_memReadEnable;
  logic        ex_regWriteEnable;
  logic [2:0]  ex_regWriteNum;
  logic        ex_halt;
  logic        ex_branchTaken;
  logic        imem_stall;
  logic        dmem_stall;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_r1Num, id_r2Num, id_r1Used, id_r2Used,
           ex_memReadEnable, ex_regWriteEnable, ex_regWriteNum,
           ex_halt, ex_branchTaken, imem_stall, dmem_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_r1Num, id_r2Num, id_r1Used, id_r2Used,
           ex_memReadEnable, ex_regWriteEnable, ex_regWriteNum,
           ex_halt, ex_branchTaken, imem_stall, dmem_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage core.
// Resolves, in priority order, data-memory stalls, taken-branch flushes,
// halt entry, load-use bubbles and instruction-memory stalls, then drains
// EX/MEM/WB after a halt before reporting the core stopped.
//
// Parameters:
//   DRAIN_CYC  cycles from halt sampled in EX to halted (EX, MEM, WB drain)
// Ports:
//   clk   core clock
//   rst   asynchronous active-low reset
//   bus   pipe_ctrl_if.slave: hazard inputs, register enables/flushes,
//         halted flag and performance counters
// Configuration macro:
//   PIPE_CTRL_PERF_EN  builds the saturating stall/flush counters; when
//                      undefined both counters read 0.
//
// Enables and flushes are combinational so that a hazard seen this cycle
// controls the very next edge. A held register has enable 0/flush 0, a
// flushed register has enable 1/flush 1.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYC = 3
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] DCNT_INIT = 2'(DRAIN_CYC - 1);

  state_t     state_r;
  logic [1:0] dcnt_r;

  logic load_use_s;
  logic halt_take_s;
  logic pc_en_s;
  logic ifid_en_s;
  logic idex_en_s;
  logic exmem_en_s;
  logic memwb_en_s;
  logic ifid_flush_s;
  logic idex_flush_s;

  // A load in EX whose destination feeds an ID source needs one bubble.
  assign load_use_s = bus.ex_memReadEnable & bus.ex_regWriteEnable &
                      ((bus.id_r1Used & (bus.id_r1Num == bus.ex_regWriteNum)) |
                       (bus.id_r2Used & (bus.id_r2Num == bus.ex_regWriteNum)));

  // Halt is taken only when the pipe advances and no redirect overrides it.
  assign halt_take_s = bus.ex_halt & ~bus.ex_branchTaken & ~bus.dmem_stall;

  // Per-register enable/flush decode from state and current hazards.
  always_comb begin
    pc_en_s      = 1'b0;
    ifid_en_s    = 1'b0;
    idex_en_s    = 1'b0;
    exmem_en_s   = 1'b0;
    memwb_en_s   = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    if (!rst) begin
      // Hold NOPs in the front registers while reset is asserted.
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.dmem_stall) begin
            // Whole pipe frozen; defaults already hold every register.
            pc_en_s = 1'b0;
          end else if (bus.ex_branchTaken) begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (bus.ex_halt) begin
            // Stop fetching; everything behind the halt becomes NOPs.
            ifid_en_s    = 1'b1;
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            // Hold PC and IF/ID, inject one bubble into EX.
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            idex_flush_s = 1'b1;
          end else if (bus.imem_stall) begin
            ifid_en_s    = 1'b1;
            idex_en_s    = 1'b1;
            exmem_en_s   = 1'b1;
            memwb_en_s   = 1'b1;
            ifid_flush_s = 1'b1;
          end else begin
            pc_en_s    = 1'b1;
            ifid_en_s  = 1'b1;
            idex_en_s  = 1'b1;
            exmem_en_s = 1'b1;
            memwb_en_s = 1'b1;
          end
        end
        ST_DRAIN: begin
          ifid_en_s    = 1'b1;
          idex_en_s    = 1'b1;
          exmem_en_s   = ~bus.dmem_stall;
          memwb_en_s   = ~bus.dmem_stall;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end
        ST_HALTED: begin
          pc_en_s = 1'b0;
        end
        default: begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end
      endcase
    end
  end

  // Sequencing FSM: RUN until a halt is taken, count down the drain, stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
      dcnt_r  <= 2'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_take_s) begin
            state_r <= ST_DRAIN;
            dcnt_r  <= DCNT_INIT;
          end else begin
            state_r <= ST_RUN;
            dcnt_r  <= dcnt_r;
          end
        end
        ST_DRAIN: begin
          // A data-memory stall freezes MEM/WB, so the drain pauses too.
          if (bus.dmem_stall) begin
            state_r <= ST_DRAIN;
            dcnt_r  <= dcnt_r;
          end else if (dcnt_r == 2'd0) begin
            state_r <= ST_HALTED;
            dcnt_r  <= 2'd0;
          end else begin
            state_r <= ST_DRAIN;
            dcnt_r  <= dcnt_r - 2'd1;
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
          dcnt_r  <= 2'd0;
        end
        default: begin
          state_r <= ST_RUN;
          dcnt_r  <= 2'd0;
        end
      endcase
    end
  end

  assign bus.pc_en      = pc_en_s;
  assign bus.ifid_en    = ifid_en_s;
  assign bus.idex_en    = idex_en_s;
  assign bus.exmem_en   = exmem_en_s;
  assign bus.memwb_en   = memwb_en_s;
  assign bus.ifid_flush = ifid_flush_s;
  assign bus.idex_flush = idex_flush_s;
  assign bus.halted     = rst & (state_r == ST_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic        stall_inc_s;
  logic        flush_inc_s;
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Count only hazards that actually shaped the outputs in RUN.
  assign stall_inc_s = (state_r == ST_RUN) &
                       (bus.dmem_stall |
                        (~bus.ex_branchTaken & ~bus.ex_halt & load_use_s));
  assign flush_inc_s = (state_r == ST_RUN) & ~bus.dmem_stall & bus.ex_branchTaken;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (stall_inc_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = 16'h0000;
  assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl. Output vectors are
// packed as {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//            ifid_flush, idex_flush, halted}.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] V_RST    = 8'b00000_11_0;
  localparam logic [7:0] V_RUN    = 8'b11111_00_0;
  localparam logic [7:0] V_FRZ    = 8'b00000_00_0;
  localparam logic [7:0] V_BR     = 8'b11111_11_0;
  localparam logic [7:0] V_LU     = 8'b00111_01_0;
  localparam logic [7:0] V_IMEM   = 8'b01111_10_0;
  localparam logic [7:0] V_HALT   = 8'b01111_11_0;
  localparam logic [7:0] V_DRSTL  = 8'b01100_11_0;
  localparam logic [7:0] V_HALTED = 8'b00000_00_1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DRAIN_CYC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.halted};
  endfunction

  task automatic chk_out(input string tag, input logic [7:0] exp_v);
    #1;
    check_val(tag, 32'(out_vec()), 32'(exp_v));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp_stall,
                         input logic [15:0] exp_flush);
    check_val({tag, "_stall"}, 32'(bus.stall_cnt), 32'(exp_stall));
    check_val({tag, "_flush"}, 32'(bus.flush_cnt), 32'(exp_flush));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_r1Num          = 3'd0;
    bus.id_r2Num          = 3'd0;
    bus.id_r1Used         = 1'b0;
    bus.id_r2Used         = 1'b0;
    bus.ex_memReadEnable  = 1'b0;
    bus.ex_regWriteEnable = 1'b0;
    bus.ex_regWriteNum    = 3'd0;
    bus.ex_halt           = 1'b0;
    bus.ex_branchTaken    = 1'b0;
    bus.imem_stall        = 1'b0;
    bus.dmem_stall        = 1'b0;
  endtask

  // Load of r3 in EX, decode reads r3 through its second source.
  task automatic set_lu();
    bus.ex_memReadEnable  = 1'b1;
    bus.ex_regWriteEnable = 1'b1;
    bus.ex_regWriteNum    = 3'd3;
    bus.id_r2Num          = 3'd3;
    bus.id_r2Used         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle();
    #2;
    check_val("rst_vec", 32'(out_vec()), 32'(V_RST));
    chk_cnt("rst_cnt", 16'd0, 16'd0);
    tick();
    rst = 1'b1;
    chk_out("run_idle", V_RUN);

    // Load-use detection and single bubble.
    bus.ex_memReadEnable  = 1'b1;
    bus.ex_regWriteEnable = 1'b1;
    bus.ex_regWriteNum    = 3'd3;
    bus.id_r1Num          = 3'd3;
    bus.id_r1Used         = 1'b0;
    bus.id_r2Num          = 3'd5;
    bus.id_r2Used         = 1'b1;
    chk_out("lu_r1_unused", V_RUN);
    bus.id_r1Used         = 1'b1;
    bus.ex_regWriteEnable = 1'b0;
    chk_out("lu_nowrite", V_RUN);
    bus.ex_regWriteEnable = 1'b1;
    chk_out("lu_r1", V_LU);
    bus.id_r1Used = 1'b0;
    bus.id_r2Num  = 3'd3;
    chk_out("lu_r2", V_LU);
    tick();
    bus.ex_memReadEnable = 1'b0;
    chk_out("lu_release", V_RUN);
    chk_cnt("lu_cnt", PERF ? 16'd1 : 16'd0, 16'd0);

    // Taken branch overrides a concurrent load-use match.
    do_reset();
    set_lu();
    bus.ex_branchTaken = 1'b1;
    chk_out("br_over_lu", V_BR);
    tick();
    idle();
    chk_out("br_after", V_RUN);
    chk_cnt("br_cnt", 16'd0, PERF ? 16'd1 : 16'd0);

    // Data-memory stall freezes a pending branch for four cycles.
    do_reset();
    bus.ex_branchTaken = 1'b1;
    bus.dmem_stall     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out("dmem_frz", V_FRZ);
      tick();
    end
    bus.dmem_stall = 1'b0;
    chk_out("dmem_then_br", V_BR);
    tick();
    idle();
    chk_cnt("dmem_cnt", PERF ? 16'd4 : 16'd0, PERF ? 16'd1 : 16'd0);

    // Priority among the remaining hazards (combinational only).
    bus.imem_stall = 1'b1;
    chk_out("imem", V_IMEM);
    bus.ex_branchTaken = 1'b1;
    chk_out("br_over_imem", V_BR);
    bus.ex_branchTaken = 1'b0;
    set_lu();
    chk_out("lu_over_imem", V_LU);
    bus.dmem_stall = 1'b1;
    chk_out("dmem_over_lu", V_FRZ);
    idle();

    // Halt drain with one data-memory stall cycle inside the drain.
    do_reset();
    bus.ex_halt        = 1'b1;
    bus.ex_branchTaken = 1'b1;
    chk_out("br_over_halt", V_BR);
    tick();
    idle();
    chk_out("no_drain_after_br", V_RUN);
    bus.ex_halt    = 1'b1;
    bus.dmem_stall = 1'b1;
    chk_out("halt_dmem_frz", V_FRZ);
    tick();
    bus.dmem_stall = 1'b0;
    chk_out("halt_run", V_HALT);
    tick();
    bus.ex_halt    = 1'b0;
    bus.dmem_stall = 1'b1;
    chk_out("drain_stall", V_DRSTL);
    tick();
    bus.dmem_stall     = 1'b0;
    bus.ex_branchTaken = 1'b1;
    set_lu();
    chk_out("drain_1", V_HALT);
    tick();
    chk_out("drain_2", V_HALT);
    tick();
    chk_out("drain_3", V_HALT);
    tick();
    chk_out("halted", V_HALTED);
    idle();
    tick();
    chk_out("halted_hold", V_HALTED);
    chk_cnt("halt_cnt", PERF ? 16'd1 : 16'd0, PERF ? 16'd1 : 16'd0);

    // Reset asserted mid-drain takes effect before the next edge.
    do_reset();
    bus.ex_halt = 1'b1;
    tick();
    bus.ex_halt = 1'b0;
    chk_out("f_drain", V_HALT);
    rst = 1'b0;
    chk_out("rst_mid_drain", V_RST);
    tick();
    rst = 1'b1;
    chk_out("run_after_rst", V_RUN);
    tick();
    chk_out("run_no_residue", V_RUN);
    chk_cnt("rst_drain_cnt", 16'd0, 16'd0);

    // Reset asserted during a memory stall.
    bus.dmem_stall = 1'b1;
    chk_out("stall_pre_rst", V_FRZ);
    rst = 1'b0;
    chk_out("rst_mid_stall", V_RST);
    tick();
    rst = 1'b1;
    idle();
    chk_out("run_after_stall_rst", V_RUN);

    // Long load-use stall saturates the stall counter.
    do_reset();
    set_lu();
    for (int i = 0; i < 70000; i++) begin
      tick();
    end
    chk_out("lu_long", V_LU);
    chk_cnt("sat_cnt", PERF ? 16'hFFFF : 16'd0, 16'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
